// File: rtl/sort4_8bit_seq.sv
// -----------------------------------------------------------------------------
// sort4_8bit_seq -- sequential sorter for four signed 8-bit operands.
//
// A single signed less-than comparator (lth_8bit) is time-shared across six
// compare-exchange steps. These steps form a bubble-sort network over the
// registers r0..r3. The design does one compare and at most one swap per clock.
//
// Ports
//   clk          in   sole clock, rising edge
//   rst          in   asynchronous, active-high reset
//   start        in   sort request, sampled on a rising edge in IDLE or DONE
//   x0..x3       in   signed operands, captured only on the accepting edge
//   busy         out  high while a sort is in progress (SORT state)
//   done         out  one-cycle pulse; y0..y3 hold the final result
//   y0..y3       out  sorted elements, driven straight from r0..r3
//   dbg_state_o  out  FSM state encoding (IDLE=0, SORT=1, DONE=2)
//   dbg_step_o   out  current compare-exchange step (0..5)
//   dbg_swap_o   out  high in the cycle after an edge that swapped a pair
//
// Handshake: a sort is accepted on any rising edge where start=1 and the FSM
// is in IDLE or DONE. While busy=1, start is ignored. The result is valid in
// the single cycle where done=1, and it stays stable in IDLE until the next
// accepted start. There is no back-pressure: done is a pulse, not a valid
// that waits for a ready.
//
// Timing: the accepting edge is edge 1. Edges 2..7 run steps 0..5, and done
// is high in the cycle after edge 7. With start held high, this gives one sort
// every 7 cycles.
// -----------------------------------------------------------------------------

// Signed 8-bit less-than: r = (x < y) in two's complement.
// The sign of x - y is corrected by the overflow flag (sign XOR overflow).
// As a result, -128 and 127 order correctly without a behavioural '<'.
module lth_8bit (
  input  logic [7:0] x,
  input  logic [7:0] y,
  output logic       r
);
  logic [7:0] diff;
  logic       ovf;

  assign diff = x - y;
  // Overflow only when the operand signs differ and the result sign
  // disagrees with the minuend.
  assign ovf  = (x[7] ^ y[7]) & (diff[7] ^ x[7]);
  assign r    = diff[7] ^ ovf;
endmodule

module sort4_8bit_seq #(
  parameter bit DESCENDING = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic [7:0] x3,
  output logic       busy,
  output logic       done,
  output logic [7:0] y0,
  output logic [7:0] y1,
  output logic [7:0] y2,
  output logic [7:0] y3,
  output logic [1:0] dbg_state_o,
  output logic [2:0] dbg_step_o,
  output logic       dbg_swap_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q;
  logic [2:0] step_q;
  logic [7:0] r_q [4];
  logic       busy_q;
  logic       done_q;
  logic       swap_q;

  // ---------------------------------------------------------------------------
  // Pair selection for the current step.
  // Schedule: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1)
  // ---------------------------------------------------------------------------
  logic [1:0] pair_lo_d;
  logic [1:0] pair_hi_d;
  logic [7:0] lo_val_d;
  logic [7:0] hi_val_d;
  logic [7:0] cmp_x_d;
  logic [7:0] cmp_y_d;
  logic       swap_d;

  always_comb begin
    pair_lo_d = 2'd0;
    case (step_q)
      3'd0:    pair_lo_d = 2'd0;
      3'd1:    pair_lo_d = 2'd1;
      3'd2:    pair_lo_d = 2'd2;
      3'd3:    pair_lo_d = 2'd0;
      3'd4:    pair_lo_d = 2'd1;
      3'd5:    pair_lo_d = 2'd0;
      default: pair_lo_d = 2'd0;
    endcase
  end

  assign pair_hi_d = pair_lo_d + 2'd1;
  assign lo_val_d  = r_q[pair_lo_d];
  assign hi_val_d  = r_q[pair_hi_d];

  // Ascending: swap when r[j+1] < r[j]. Descending: swap when r[j] < r[j+1].
  // Equal values never satisfy a strict less-than, so the sort is stable.
  assign cmp_x_d = DESCENDING ? lo_val_d : hi_val_d;
  assign cmp_y_d = DESCENDING ? hi_val_d : lo_val_d;

  lth_8bit u_lth (
    .x (cmp_x_d),
    .y (cmp_y_d),
    .r (swap_d)
  );

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 3'd0;
      r_q[0]  <= 8'd0;
      r_q[1]  <= 8'd0;
      r_q[2]  <= 8'd0;
      r_q[3]  <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          swap_q <= 1'b0;
          if (start) begin
            r_q[0]  <= x0;
            r_q[1]  <= x1;
            r_q[2]  <= x2;
            r_q[3]  <= x3;
            step_q  <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= SORT;
          end else begin
            busy_q <= 1'b0;
          end
        end

        SORT: begin
          swap_q <= swap_d;
          if (swap_d) begin
            r_q[pair_lo_d] <= hi_val_d;
            r_q[pair_hi_d] <= lo_val_d;
          end
          // A value >= 5 also terminates, so a corrupted step cannot run away.
          if (step_q >= 3'd5) begin
            step_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            step_q <= step_q + 3'd1;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          swap_q <= 1'b0;
          step_q <= 3'd0;
          // Back-to-back request: reload directly from DONE.
          if (start) begin
            r_q[0]  <= x0;
            r_q[1]  <= x1;
            r_q[2]  <= x2;
            r_q[3]  <= x3;
            busy_q  <= 1'b1;
            state_q <= SORT;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          // Illegal encoding: recover to IDLE and keep the registers.
          state_q <= IDLE;
          step_q  <= 3'd0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          swap_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign y0          = r_q[0];
  assign y1          = r_q[1];
  assign y2          = r_q[2];
  assign y3          = r_q[3];
  assign dbg_state_o = state_q;
  assign dbg_step_o  = step_q;
  assign dbg_swap_o  = swap_q;

endmodule

// File: tb/tb_sort4_8bit_seq.sv
// -----------------------------------------------------------------------------
// Bench for sort4_8bit_seq. One ascending and one descending instance share
// all inputs. Every expected vector below is worked out by hand.
// Negative values are written in hex: FF=-1 FE=-2 FD=-3 FC=-4 80=-128 7F=127.
// -----------------------------------------------------------------------------
module tb_sort4_8bit_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x0 = 8'd0, x1 = 8'd0, x2 = 8'd0, x3 = 8'd0;

  logic       busy_a, done_a, swap_a;
  logic [7:0] ya0, ya1, ya2, ya3;
  logic [1:0] state_a;
  logic [2:0] step_a;

  logic       busy_d, done_d, swap_d;
  logic [7:0] yd0, yd1, yd2, yd3;
  logic [1:0] state_d;
  logic [2:0] step_d;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, expected normal completion");
    $fatal(1);
  end

  sort4_8bit_seq #(.DESCENDING(1'b0)) dut_a (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .busy(busy_a), .done(done_a),
    .y0(ya0), .y1(ya1), .y2(ya2), .y3(ya3),
    .dbg_state_o(state_a), .dbg_step_o(step_a), .dbg_swap_o(swap_a)
  );

  sort4_8bit_seq #(.DESCENDING(1'b1)) dut_d (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .busy(busy_d), .done(done_d),
    .y0(yd0), .y1(yd1), .y2(yd2), .y3(yd3),
    .dbg_state_o(state_d), .dbg_step_o(step_d), .dbg_swap_o(swap_d)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ya(input string tag, input logic [7:0] e0, e1, e2, e3);
    check({tag, " ya0"}, {24'd0, ya0}, {24'd0, e0});
    check({tag, " ya1"}, {24'd0, ya1}, {24'd0, e1});
    check({tag, " ya2"}, {24'd0, ya2}, {24'd0, e2});
    check({tag, " ya3"}, {24'd0, ya3}, {24'd0, e3});
  endtask

  task automatic check_yd(input string tag, input logic [7:0] e0, e1, e2, e3);
    check({tag, " yd0"}, {24'd0, yd0}, {24'd0, e0});
    check({tag, " yd1"}, {24'd0, yd1}, {24'd0, e1});
    check({tag, " yd2"}, {24'd0, yd2}, {24'd0, e2});
    check({tag, " yd3"}, {24'd0, yd3}, {24'd0, e3});
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_x(input logic [7:0] a, b, c, d);
    x0 = a; x1 = b; x2 = c; x3 = d;
  endtask

  // Pulse start for one edge, then check busy/done timing and both results.
  task automatic sort_check(input string tag,
                            input logic [7:0] a, b, c, d,
                            input logic [7:0] ea0, ea1, ea2, ea3,
                            input logic [7:0] ed0, ed1, ed2, ed3);
    int busy_cnt;
    int early_done;
    busy_cnt   = 0;
    early_done = 0;
    @(negedge clk);
    drive_x(a, b, c, d);
    start = 1'b1;
    @(posedge clk);              // edge 1: accept
    #1 start = 1'b0;
    repeat (6) begin             // cycles after edges 1..6
      @(negedge clk);
      if (busy_a) busy_cnt++;
      if (done_a || done_d) early_done++;
    end
    check({tag, " busy cycles"}, busy_cnt, 6);
    check({tag, " early done"}, early_done, 0);
    @(negedge clk);              // cycle after edge 7
    check({tag, " done_a"}, {31'd0, done_a}, 32'd1);
    check({tag, " done_d"}, {31'd0, done_d}, 32'd1);
    check({tag, " busy at done"}, {31'd0, busy_a}, 32'd0);
    check_ya(tag, ea0, ea1, ea2, ea3);
    check_yd(tag, ed0, ed1, ed2, ed3);
    @(negedge clk);              // back in IDLE, result held
    check({tag, " done pulse width"}, {31'd0, done_a}, 32'd0);
    check({tag, " idle state"}, {30'd0, state_a}, 32'd0);
    check_ya({tag, " held"}, ea0, ea1, ea2, ea3);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] tr_y [6][4];
  logic       tr_s [6];
  int dones;
  int done_cyc [$];

  initial begin
    // Test 1: async reset between edges takes effect without a clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst busy", {31'd0, busy_a}, 32'd0);
    check("rst done", {31'd0, done_a}, 32'd0);
    check("rst state", {30'd0, state_a}, 32'd0);
    check_ya("rst", 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Test 2: mixed signs with extremes.
    sort_check("t2", 8'd5, 8'hFD, 8'h7F, 8'h80,
               8'h80, 8'hFD, 8'd5, 8'h7F,
               8'h7F, 8'd5, 8'hFD, 8'h80);

    // Test 3: overflow extremes and a tie-heavy vector.
    sort_check("t3a", 8'h7F, 8'h80, 8'h00, 8'hFF,
               8'h80, 8'hFF, 8'h00, 8'h7F,
               8'h7F, 8'h00, 8'hFF, 8'h80);
    sort_check("t3b", 8'd7, 8'd7, 8'hFF, 8'd7,
               8'hFF, 8'd7, 8'd7, 8'd7,
               8'd7, 8'd7, 8'd7, 8'hFF);

    // Test 3 swap trace, ascending, x=(7,7,-1,7):
    //   s0 (0,1) 7,7   no  -> 7,7,-1,7
    //   s1 (1,2) 7,-1  yes -> 7,-1,7,7
    //   s2 (2,3) 7,7   no  -> 7,-1,7,7
    //   s3 (0,1) 7,-1  yes -> -1,7,7,7
    //   s4 (1,2) 7,7   no ; s5 (0,1) -1,7 no
    tr_y[0] = '{8'd7, 8'd7, 8'hFF, 8'd7};  tr_s[0] = 1'b0;
    tr_y[1] = '{8'd7, 8'hFF, 8'd7, 8'd7};  tr_s[1] = 1'b1;
    tr_y[2] = '{8'd7, 8'hFF, 8'd7, 8'd7};  tr_s[2] = 1'b0;
    tr_y[3] = '{8'hFF, 8'd7, 8'd7, 8'd7};  tr_s[3] = 1'b1;
    tr_y[4] = '{8'hFF, 8'd7, 8'd7, 8'd7};  tr_s[4] = 1'b0;
    tr_y[5] = '{8'hFF, 8'd7, 8'd7, 8'd7};  tr_s[5] = 1'b0;
    @(negedge clk);
    drive_x(8'd7, 8'd7, 8'hFF, 8'd7);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int s = 0; s < 6; s++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("trace s%0d swap", s), {31'd0, swap_a}, {31'd0, tr_s[s]});
      check_ya($sformatf("trace s%0d", s), tr_y[s][0], tr_y[s][1], tr_y[s][2], tr_y[s][3]);
    end
    repeat (2) @(negedge clk);

    // Test 4: descending.
    sort_check("t4", 8'd1, 8'hFE, 8'd3, 8'hFC,
               8'hFC, 8'hFE, 8'd1, 8'd3,
               8'd3, 8'd1, 8'hFE, 8'hFC);

    // Test 5: start re-pulsed at step 2 with new operands -> ignored.
    @(negedge clk);
    drive_x(8'd5, 8'hFD, 8'h7F, 8'h80);
    start = 1'b1;
    @(posedge clk);              // edge 1
    #1 start = 1'b0;
    @(posedge clk);              // edge 2: step 0
    @(posedge clk);              // edge 3: step 1
    #1;
    check("t5 step", {29'd0, step_a}, 32'd2);
    drive_x(8'd0, 8'd0, 8'd0, 8'd0);
    start = 1'b1;
    @(posedge clk);              // edge 4: step 2, start ignored
    #1 start = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_a) begin
        dones++;
        check_ya("t5", 8'h80, 8'hFD, 8'd5, 8'h7F);
      end
    end
    check("t5 done count", dones, 1);

    // Test 6: reset mid-sort at step 3, then a fresh sort.
    @(negedge clk);
    drive_x(8'd5, 8'hFD, 8'h7F, 8'h80);
    start = 1'b1;
    @(posedge clk);              // edge 1
    #1 start = 1'b0;
    repeat (3) @(posedge clk);   // edges 2..4: steps 0..2
    #2;
    check("t6 step", {29'd0, step_a}, 32'd3);
    rst = 1'b1;
    #1;
    check("t6 rst busy", {31'd0, busy_a}, 32'd0);
    check("t6 rst done", {31'd0, done_a}, 32'd0);
    check_ya("t6 rst", 8'h00, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_a) dones++;
    end
    check("t6 aborted done", dones, 0);
    sort_check("t6", 8'd4, 8'd3, 8'd2, 8'd1,
               8'd1, 8'd2, 8'd3, 8'd4,
               8'd4, 8'd3, 8'd2, 8'd1);

    // Test 6b: start held high -> done every 7th cycle, each DONE reloads.
    @(negedge clk);
    drive_x(8'd4, 8'd3, 8'd2, 8'd1);
    start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a) begin
        done_cyc.push_back(c);
        check_ya($sformatf("held c%0d", c), 8'd1, 8'd2, 8'd3, 8'd4);
      end
    end
    start = 1'b0;
    check("held done count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      check("held first done", done_cyc[0], 7);
      check("held period 1", done_cyc[1] - done_cyc[0], 7);
      check("held period 2", done_cyc[2] - done_cyc[1], 7);
    end
    repeat (10) @(negedge clk);
    check("final idle", {30'd0, state_a}, 32'd0);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sort4_8bit_seq.md
Name: sort4_8bit_seq

Overview:
Sequential sorter for four signed 8-bit operands. It shares a single lth_8bit comparator instance across six compare-exchange steps under a small FSM. The block is the control layer that schedules the comparator datapath for a start/done requester, for example a min/max or median stage in the ALU test harness. It trades area for latency: one comparator and one swap per clock.

Parameters:
DESCENDING, 0, 0 = output ascending (y0 smallest); 1 = output descending (y0 largest).

Ports:
clk  input  1  sole clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
start  input  1  request a sort; sampled on rising clk edge.
x0  input  8  signed operand 0.
x1  input  8  signed operand 1.
x2  input  8  signed operand 2.
x3  input  8  signed operand 3.
busy  output  1  high while a sort is in progress.
done  output  1  one-cycle pulse; y0..y3 hold the final sorted result.
y0  output  8  signed sorted element 0 (register r0).
y1  output  8  signed sorted element 1 (register r1).
y2  output  8  signed sorted element 2 (register r2).
y3  output  8  signed sorted element 3 (register r3).

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset (async, any state, including mid-sort):
  - state=IDLE, step=0, r0..r3=0.
  - busy=0, done=0, therefore y0..y3=0.
  - An in-flight sort is abandoned; no done pulse follows.
- State register, one-hot or binary: IDLE, SORT, DONE.
- IDLE:
  - busy=0, done=0; r0..r3 hold the previous result.
  - start=1 at an edge: r0..r3 <= x0..x3, step <= 0, go to SORT.
- SORT:
  - busy=1, done=0; start is ignored.
  - Each edge executes one compare-exchange on pair (rj, rj+1) selected by step.
  - Schedule: step0 (0,1), step1 (1,2), step2 (2,3), step3 (0,1), step4 (1,2), step5 (0,1).
  - Comparator operands: x=rj+1, y=rj when DESCENDING=0; x=rj, y=rj+1 when DESCENDING=1.
  - Swap rj and rj+1 iff the comparator output r=1. Equal values never swap (stable).
  - step increments by 1 each edge. On the step5 edge, go to DONE and clear step to 0.
- DONE:
  - busy=0, done=1 for exactly this one cycle; y0..y3 are final.
  - Next edge: start=1 reloads and enters SORT (back-to-back accepted); otherwise go to IDLE.
- Latency: the start-sampling edge is edge 1. Edges 2..7 perform steps 0..5, and done is high in the cycle after edge 7.
- Throughput: one sort per 7 cycles when start is held high.
- Arithmetic:
  - All comparisons are full 8-bit two's-complement, via lth_8bit only (sign XOR overflow).
  - No behavioural < operator is used on operands.
  - Extremes -128 and 127 must order correctly.
- y0..y3 are driven directly from r0..r3. Values are intermediate during SORT and are valid only when done=1 or in IDLE after a completed sort.
- x0..x3 are sampled only on the accepting edge. Changes during SORT have no effect.
- step never exceeds 5. An illegal state encoding recovers to IDLE on the next edge.

Test Plan:
1. Reset asserted asynchronously between edges -> busy=0, done=0 and y0..y3=0 immediately, without waiting for a clock edge.
2. DESCENDING=0, x=(5,-3,127,-128), start pulse -> done high in the cycle after edge 7, y=(-128,-3,5,127); busy high for exactly 6 cycles.
3. DESCENDING=0, x=(127,-128,0,-1) (overflow extremes) -> y=(-128,-1,0,127). Also run x=(7,7,-1,7) -> y=(-1,7,7,7) with no spurious swaps of equal values (check that the per-step swap trace never swaps equals).
4. DESCENDING=1, x=(1,-2,3,-4) -> y=(3,1,-2,-4).
5. start pulsed again at SORT step 2 with different x -> ignored; the result matches the original operands; a single done pulse.
6. rst pulsed at SORT step 3, then start with x=(4,3,2,1) -> outputs cleared at reset, no done from the aborted sort, then y=(1,2,3,4) seven edges later. Also hold start high continuously -> done every 7th cycle and each DONE cycle reloads.
